// File: rtl/seq_shift_rotate.sv
// Multi-cycle shifter/rotator (SHR, SHRA, SHL, ROR, ROL), one position per clock by default.
// Defining SEQ_SHIFT_ROTATE_FAST_STEP_EN moves up to four positions per clock; results are identical.
module seq_shift_rotate #(
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             op_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;

    // One-position move; returns {bit that left, new register value}.
    function automatic logic [WIDTH:0] step1(input logic [2:0] o, input logic [WIDTH-1:0] v);
        case (o)
            OP_SHR:  step1 = {v[0], 1'b0, v[WIDTH-1:1]};
            OP_SHRA: step1 = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
            OP_SHL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
            OP_ROR:  step1 = {v[0], v[0], v[WIDTH-1:1]};
            OP_ROL:  step1 = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
            default: step1 = {1'b0, v};
        endcase
    endfunction

`ifdef SEQ_SHIFT_ROTATE_FAST_STEP_EN
    int               stp;
    logic [WIDTH:0]   acc;
`endif

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        err_d   = err_q;
`ifdef SEQ_SHIFT_ROTATE_FAST_STEP_EN
        stp     = 0;
        acc     = {1'b0, reg_q};
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    reg_d   = data_in;
                    op_d    = op;
                    // Illegal codes run as a zero-length pass-through.
                    cnt_d   = (op > OP_ROL) ? '0 : amount;
                    carry_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    err_d   = (op_q > OP_ROL);
                end else begin
`ifdef SEQ_SHIFT_ROTATE_FAST_STEP_EN
                    stp = (32'(cnt_q) > 4) ? 4 : int'(32'(cnt_q));
                    for (int i = 0; i < 4; i++) begin
                        if (i < stp) begin
                            acc = step1(op_q, acc[WIDTH-1:0]);
                        end
                    end
                    {carry_d, reg_d} = acc;
                    cnt_d            = cnt_q - AMT_W'(stp);
`else
                    {carry_d, reg_d} = step1(op_q, reg_q);
                    cnt_d            = cnt_q - 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= IDLE;
            reg_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign result    = reg_q;
    assign carry_out = carry_q;
    assign op_err    = err_q;

endmodule
